adder_share_ctrl: RTL



---
 rtl/adder_share_ctrl_if.sv | 29 ++
 rtl/adder_share_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/adder_share_ctrl_if.sv
// Bundle of request, shared-adder and response signals for adder_share_ctrl.
// The master side is the client/adder environment; the slave side is the controller.
interface adder_share_ctrl_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]         add_a;
  logic [WIDTH-1:0]         add_b;
  logic [WIDTH-1:0]         add_y;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [WIDTH-1:0]         resp_sum;
  logic [ID_W-1:0]          resp_id;

  modport master (
    output req_valid, req_a, req_b, resp_ready, add_y,
    input  req_ready, add_a, add_b, resp_valid, resp_sum, resp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, add_y,
    output req_ready, add_a, add_b, resp_valid, resp_sum, resp_id
  );
endinterface

// File: rtl/adder_share_ctrl.sv
// Round-robin arbiter/sequencer time-sharing one combinational adder between
// NUM_REQ requesters; one transaction in flight, response tagged with requester index.
module adder_share_ctrl #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  adder_share_ctrl_if.slave  bus,
  output logic               busy,
  output logic [15:0]        op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [ID_W-1:0]  resp_id_q;
  logic [WIDTH-1:0] add_a_q;
  logic [WIDTH-1:0] add_b_q;
  logic [WIDTH-1:0] resp_sum_q;
  logic             resp_valid_q;
  logic [15:0]      op_count_q;

  logic             grant_valid;
  logic [ID_W-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_a;
  logic [WIDTH-1:0] grant_b;
  logic [ID_W-1:0]  next_ptr;

  // Two passes: first look at indices >= rr_ptr, then wrap around to the low ones.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_a     = '0;
    grant_b     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && bus.req_valid[i] && (i >= 32'(rr_ptr_q))) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(i);
        grant_a     = bus.req_a[i*WIDTH +: WIDTH];
        grant_b     = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_valid && bus.req_valid[i]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(i);
        grant_a     = bus.req_a[i*WIDTH +: WIDTH];
        grant_b     = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = (state_q == StIdle) && grant_valid && (32'(grant_idx) == i);
    end
  end

  assign next_ptr = (32'(resp_id_q) == NUM_REQ - 1) ? '0 : resp_id_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      resp_id_q    <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      resp_sum_q   <= '0;
      resp_valid_q <= 1'b0;
      op_count_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            add_a_q   <= grant_a;
            add_b_q   <= grant_b;
            resp_id_q <= grant_idx;
            state_q   <= StExec;
          end
        end
        // Operands have been stable for a full cycle, so the ripple sum has settled.
        StExec: begin
          resp_sum_q   <= bus.add_y;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            rr_ptr_q     <= next_ptr;
            op_count_q   <= op_count_q + 16'd1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_sum   = resp_sum_q;
  assign bus.resp_id    = resp_id_q;
  assign busy           = (state_q != StIdle);
  assign op_count       = op_count_q;

endmodule
